// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
//   fetch_state_e : controller states (RUN, HALTED, FAULT)
//   fetch_entry_t : one buffered fetch result {pc, instr}
//   INSN_NOP      : canonical RV32I nop encoding (addi x0, x0, 0)
//   PC_STEP       : sequential fetch increment in bytes
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] INSN_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of the fetch controller's memory, redirect, halt and decode
// handshake signals.
//   master : the fetch controller side (drives imem_addr and inst_*)
//   slave  : memory / execute / decode side
interface imem_fetch_ctrl_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  modport master (
    output imem_addr,
    input  imem_data,
    input  redirect_valid,
    input  redirect_pc,
    input  halt,
    output inst_valid,
    input  inst_ready,
    output inst_data,
    output inst_pc,
    output fetch_fault
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output redirect_valid,
    output redirect_pc,
    output halt,
    input  inst_valid,
    output inst_ready,
    input  inst_data,
    input  inst_pc,
    input  fetch_fault
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch_entry_t with flush.
//   clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//   i_push     : write i_wdata at the tail (ignored when full without a pop)
//   i_pop      : drop the head (ignored when empty)
//   i_flush    : discard all entries; overrides push and pop
//   o_rdata    : head entry (undefined contents when empty)
//   o_empty    : no entries buffered
//   o_count    : number of buffered entries
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  fetch_entry_t             i_wdata,
  output fetch_entry_t             o_rdata,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  fetch_entry_t    r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_FULL);
  assign w_pop   = i_pop & ~w_empty & ~i_flush;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push.
  assign w_push  = i_push & (~w_full | w_pop) & ~i_flush;

  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = w_empty;
  assign o_count = r_count;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer in front of an asynchronous-read instruction memory.
// Owns the fetch PC, buffers {pc, instr} pairs in a small FIFO and hands
// them to decode over valid/ready. Handles redirects, halt and fetches
// beyond the end of memory.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : imem_fetch_ctrl_if.master (memory, redirect, halt, decode)
//
// state  | meaning
// -------+------------------------------------------------------------
// RUN    | fetching sequentially while the FIFO has room
// HALTED | halt is high; PC held, buffered entries still drain
// FAULT  | PC ran past memory; only a redirect or reset leaves
module imem_fetch_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input logic               clk,
  input logic               rst_n,
  imem_fetch_ctrl_if.master bus
);

  localparam logic [1:0] ST_RUN    = RUN;
  localparam logic [1:0] ST_HALTED = HALTED;
  localparam logic [1:0] ST_FAULT  = FAULT;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
  // 33 bits so a 4 GiB memory limit does not wrap to zero.
  localparam logic [32:0] PC_LIMIT = 33'(IMEM_WORDS) * 33'd4;

  logic [1:0]    r_state;
  logic [31:0]   r_pc;

  logic          w_in_range;
  logic          w_valid;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic [CW-1:0] w_count;
  fetch_entry_t  w_wdata;
  fetch_entry_t  w_head;

  assign w_in_range = ({1'b0, r_pc} < PC_LIMIT);
  assign w_valid    = ~w_empty;
  assign w_full     = (w_count == CNT_FULL);
  assign w_pop      = w_valid & bus.inst_ready;
  assign w_push     = (r_state == ST_RUN) & ~bus.halt & ~bus.redirect_valid &
                      w_in_range & (~w_full | w_pop);

  assign w_wdata.pc    = r_pc;
  assign w_wdata.instr = bus.imem_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_pc    <= RESET_PC;
    end else if (bus.redirect_valid) begin
      // Low address bits are dropped; an unaligned target fetches its word.
      r_state <= ST_RUN;
      r_pc    <= {bus.redirect_pc[31:2], 2'b00};
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.halt)          r_state <= ST_HALTED;
          else if (!w_in_range)  r_state <= ST_FAULT;
          else if (w_push)       r_pc    <= r_pc + PC_STEP;
        end
        ST_HALTED: begin
          if (!bus.halt) r_state <= ST_RUN;
        end
        ST_FAULT: r_state <= ST_FAULT;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign bus.imem_addr   = r_pc;
  assign bus.inst_valid  = w_valid;
  assign bus.inst_data   = w_valid ? w_head.instr : 32'h0;
  assign bus.inst_pc     = w_valid ? w_head.pc    : 32'h0;
  assign bus.fetch_fault = (r_state == ST_FAULT);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   n_total = 0;
  int   n_bad   = 0;

  logic [31:0] mem [1024];

  imem_fetch_ctrl_if u_if ();

  imem_fetch_ctrl #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2),
    .IMEM_WORDS (1024)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  always #5 clk = ~clk;

  assign u_if.imem_data = (u_if.imem_addr < 32'h1000) ?
                          mem[u_if.imem_addr[11:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_instr(input logic [31:0] a);
    return mem[a[11:2]];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, u_if.inst_valid}, 32'd1);
    chk({tag, "_pc"},    u_if.inst_pc,             pc);
    chk({tag, "_data"},  u_if.inst_data,           model_instr(pc));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, {31'd0, u_if.inst_valid}, 32'd0);
    chk({tag, "_pc"},    u_if.inst_pc,             32'd0);
    chk({tag, "_data"},  u_if.inst_data,           32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    chk_empty("rst");
    chk("rst_fault", {31'd0, u_if.fetch_fault}, 32'd0);
    chk("rst_addr",  u_if.imem_addr,            32'h0);
  endtask

  task automatic redirect(input logic [31:0] target);
    u_if.redirect_valid = 1'b1;
    u_if.redirect_pc    = target;
    step();
    u_if.redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0AB0_0000 + i;
    mem[0] = 32'h00A0_0093;
    mem[1] = 32'h0140_0113;
    mem[2] = 32'h0020_81B3;

    rst_n               = 1'b0;
    u_if.inst_ready     = 1'b0;
    u_if.halt           = 1'b0;
    u_if.redirect_valid = 1'b0;
    u_if.redirect_pc    = 32'h0;
    step();

    // streaming
    do_reset();
    u_if.inst_ready = 1'b1;
    rst_n = 1'b1;
    step();
    chk("str0_literal", u_if.inst_data, 32'h00A0_0093);
    chk_head("str0", 32'h0);
    step();
    chk("str1_literal", u_if.inst_data, 32'h0140_0113);
    chk_head("str1", 32'h4);
    step();
    chk("str2_literal", u_if.inst_data, 32'h0020_81B3);
    chk_head("str2", 32'h8);

    // backpressure
    do_reset();
    u_if.inst_ready = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chk_head("bp_hold", 32'h0);
    chk("bp_addr", u_if.imem_addr, 32'h8);
    u_if.inst_ready = 1'b1;
    step();
    chk_head("bp_pop1", 32'h4);
    step();
    chk_head("bp_pop2", 32'h8);
    chk("bp_addr2", u_if.imem_addr, 32'h10);

    // redirect with misaligned target
    redirect(32'h22);
    chk_empty("rd_flush");
    chk("rd_addr", u_if.imem_addr, 32'h20);
    step();
    chk_head("rd_first", 32'h20);

    // redirect while full, head handshaked in the redirect cycle
    u_if.inst_ready = 1'b0;
    step();
    chk("rdf_addr", u_if.imem_addr, 32'h28);
    u_if.inst_ready = 1'b1;
    redirect(32'h40);
    chk_empty("rdf_flush");
    chk("rdf_addr2", u_if.imem_addr, 32'h40);
    step();
    chk_head("rdf_first", 32'h40);
    step();
    chk_head("rdf_second", 32'h44);

    // fault at end of memory
    redirect(32'hFFC);
    chk("flt_addr", u_if.imem_addr, 32'hFFC);
    step();
    chk_head("flt_last", 32'hFFC);
    chk("flt_fault0", {31'd0, u_if.fetch_fault}, 32'd0);
    step();
    chk_empty("flt_nopush");
    chk("flt_fault1", {31'd0, u_if.fetch_fault}, 32'd1);
    step();
    chk_empty("flt_stay");
    chk("flt_fault2", {31'd0, u_if.fetch_fault}, 32'd1);
    chk("flt_addr2",  u_if.imem_addr, 32'h1000);
    redirect(32'h0);
    chk("flt_clr", {31'd0, u_if.fetch_fault}, 32'd0);
    chk("flt_addr3", u_if.imem_addr, 32'h0);
    step();
    chk_head("flt_resume", 32'h0);
    step();
    chk_head("flt_resume2", 32'h4);

    // halt mid-stream at pc 8
    chk("hlt_addr0", u_if.imem_addr, 32'h8);
    u_if.halt = 1'b1;
    step();
    chk_empty("hlt_drain");
    chk("hlt_addr1", u_if.imem_addr, 32'h8);
    step();
    step();
    chk("hlt_addr3", u_if.imem_addr, 32'h8);
    chk_empty("hlt_nopush");
    u_if.halt = 1'b0;
    step();
    chk("hlt_addr4", u_if.imem_addr, 32'h8);
    step();
    chk_head("hlt_resume", 32'h8);
    step();
    chk_head("hlt_resume2", 32'hC);

    // reset while full and faulted
    u_if.inst_ready = 1'b0;
    redirect(32'hFF8);
    step();
    step();
    chk("rm_addr", u_if.imem_addr, 32'h1000);
    step();
    chk("rm_fault", {31'd0, u_if.fetch_fault}, 32'd1);
    chk_head("rm_full", 32'hFF8);
    do_reset();
    rst_n = 1'b1;
    u_if.inst_ready = 1'b1;
    step();
    chk_head("rm_first", 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Fetch sequencer in front of the core's instruction memory (word-addressed, asynchronous read, `IMEM_WORDS` words).
- Owns the fetch PC and drives the memory address every cycle.
- Buffers fetched `{pc, instr}` pairs in a small FIFO and hands them to decode over a valid/ready handshake.
- Handles branch/jump redirects, an external halt, and out-of-range fetch faults.

Parameters:
- `RESET_PC`, 32'h0000_0000, fetch PC loaded at reset.
- `FIFO_DEPTH`, 2, number of buffered `{pc, instr}` entries (power of two, ≥2).
- `IMEM_WORDS`, 1024, instruction memory size in 32-bit words; byte limit is `IMEM_WORDS*4`.

Ports:
- `clk`, in, 1, single clock; all state updates on rising edge.
- `rst_n`, in, 1, reset; synchronous, active-low.
- `imem_addr`, out, 32, byte address to instruction memory; always equals `fetch_pc`.
- `imem_data`, in, 32, instruction word returned combinationally for `imem_addr`.
- `redirect_valid`, in, 1, taken branch/jump from execute; highest priority.
- `redirect_pc`, in, 32, redirect target byte address.
- `halt`, in, 1, level; suspends fetching while high.
- `inst_valid`, out, 1, FIFO head valid.
- `inst_ready`, in, 1, decode accepts the head this cycle.
- `inst_data`, out, 32, head instruction; 0 when `inst_valid`=0.
- `inst_pc`, out, 32, head PC; 0 when `inst_valid`=0.
- `fetch_fault`, out, 1, high while in FAULT state.

Behaviour:
- Reset (`rst_n`=0 at an edge): `fetch_pc` ← `RESET_PC`, FIFO emptied, state ← RUN. Outputs after reset: `inst_valid`=0, `inst_data`=0, `inst_pc`=0, `fetch_fault`=0, `imem_addr`=`RESET_PC`. Reset mid-operation discards all buffered entries with no partial state retained.
- States are `RUN`, `HALTED`, `FAULT`.
- **Push condition:** state=RUN, `halt`=0, `redirect_valid`=0, `fetch_pc` < `IMEM_WORDS*4`, and (count < `FIFO_DEPTH`, or a pop occurs this cycle). On push, `{fetch_pc, imem_data}` is written at the tail and `fetch_pc` ← `fetch_pc`+4 (mod 2^32).
- **Pop:** `inst_valid` & `inst_ready`. Push and pop in the same cycle leave count unchanged, including when full.
- **Latency:** a word pushed at edge N appears at the head with `inst_valid`=1 in cycle N+1 if the FIFO was empty. No combinational path from `imem_data` to `inst_*`.
- **Redirect (any state, highest priority):**
  - FIFO flushed, no push that cycle.
  - A head handshaked in the same cycle is treated as consumed.
  - `fetch_pc` ← `{redirect_pc[31:2], 2'b00}`; misaligned low bits are silently dropped.
  - State ← RUN (clears FAULT and exits HALTED). If `halt` is still high, the block re-enters HALTED on the next cycle.
- **HALTED:**
  - Entered from RUN when `halt`=1 (no push that cycle).
  - Returns to RUN when `halt`=0.
  - Buffered entries remain poppable; `fetch_pc` is held.
- **FAULT:**
  - Entered from RUN when `halt`=0, `redirect_valid`=0 and `fetch_pc` ≥ `IMEM_WORDS*4`; the out-of-range word is never pushed.
  - `fetch_fault`=1 from the following cycle; buffered entries still drain.
  - Only `redirect_valid` or reset leave FAULT.
- **Count/pointers:** head/tail pointers wrap modulo `FIFO_DEPTH`; count width is clog2(`FIFO_DEPTH`)+1. Never overflows or underflows; a pop request when empty is ignored.

Decomposition:
- Package `riscv_fetch_pkg`:
  - `fetch_state_e` (`RUN`, `HALTED`, `FAULT`).
  - `fetch_entry_t` struct `{logic [31:0] pc; logic [31:0] instr;}`.
  - Constant `INSN_NOP` = 32'h0000_0013.
  - Constant `PC_STEP` = 4.
- One sub-module `fetch_fifo` (parameterised depth, `fetch_entry_t` payload, push/pop/flush, full/empty/count).
- The top level holds the PC register, state machine and push logic.

Test Plan:
- **Streaming:** memory preloaded 0x00A00093 @0, 0x01400113 @4, 0x002081B3 @8; reset released, `inst_ready`=1 → cycle 1 `inst_pc`=0/`inst_data`=0x00A00093, then pc 4 = 0x01400113, pc 8 = 0x002081B3; `inst_valid` stays high every cycle.
- **Backpressure:** `inst_ready`=0 for 4 cycles after reset → FIFO holds pc 0 and 4, `imem_addr` stuck at 8. `inst_ready`=1 → pops 0, 4, 8 in order with no gap or duplicate.
- **Redirect:** while streaming at `imem_addr`=0x10, assert `redirect_valid` with `redirect_pc`=0x22 for one cycle → `inst_valid`=0 next cycle, `imem_addr`=0x20, then `inst_pc`=0x20. Repeat with the FIFO full and `inst_ready`=1 in the redirect cycle: no stale entry is ever delivered.
- **Fault:** `IMEM_WORDS`=1024, redirect to 0xFFC → pc 0xFFC delivered, then `fetch_fault`=1 and no pc 0x1000 entry. Redirect to 0x0 → `fetch_fault`=0 next cycle and fetching resumes at 0.
- **Halt:** `halt`=1 for 3 cycles mid-stream at pc 0x8 → `imem_addr` held at 0x8, existing entries drain, no push. `halt`=0 → next entry pc 0x8 without skip or duplicate.
- **Reset mid-operation:** FIFO full, state FAULT, `rst_n`=0 one edge → `inst_valid`=0, `fetch_fault`=0, `imem_addr`=`RESET_PC` on the following cycle; first entry after release is pc 0.
